lcd_de_monitor: RTL and testbench
=================================

Name: lcd_de_monitor

Overview:
- Receive-side companion to the LCD timing generator: samples the DE-mode RGB565 panel bus in the PixelClk domain and recovers frame geometry.
- Per frame, reports measured active width, active height, line period and a pixel checksum, with error flags and a lock indicator.
- Placed in the top-level beside the LCD driver and tapping the same LCD_DEN/LCD_R/LCD_G/LCD_B nets, for on-board self-check and simulation scoreboarding.

Parameters:
- H_ACTIVE, 480, expected DE-high pixels per line.
- V_ACTIVE, 272, expected active lines per frame.
- VBLANK_MIN, 1024, consecutive DE-low cycles that declare vertical blank; must exceed horizontal blank (80) and be less than vertical blank (29*560).
- CNT_W, 16, width of the internal low-run and line-period counters.

Ports:
- PixelClk  input  1  pixel clock, the only clock.
- nRST  input  1  asynchronous, active-low reset.
- LCD_DE  input  1  data enable under observation.
- LCD_R  input  5  red.
- LCD_G  input  6  green.
- LCD_B  input  5  blue.
- frame_valid  output  1  one-cycle pulse; meas_* and err_* are updated on this cycle.
- meas_width  output  12  DE-high length of the first line of the frame.
- meas_height  output  12  number of DE-high runs in the frame.
- meas_htotal  output  16  cycles from line-1 DE rise to line-2 DE rise.
- frame_sum  output  16  pixel checksum of the frame.
- err_width  output  1  some line length differed from H_ACTIVE.
- err_height  output  1  meas_height differed from V_ACTIVE.
- locked  output  1  two or more consecutive error-free frames seen.

Behaviour:
- Reset: all outputs 0, state UNSYNC, all counters 0. Reset is asynchronous and takes effect mid-frame; no partial frame is ever reported.
- Input stage: DE and RGB are registered once. All logic below uses the registered values (d_de, d_pix = {R,G,B}).
- low_cnt: counts consecutive d_de=0 cycles, starting at 1 on the first low cycle, saturating at 2^CNT_W-1; cleared when d_de=1.
- UNSYNC: ignore data. When low_cnt==VBLANK_MIN, go to VBLANK. No frame_valid is issued on this transition.
- VBLANK, d_de=1: go to ACTIVE; line_cnt=1; pix_cnt=1; per-frame accumulators reset and seeded with d_pix; htot_cnt=1.
- ACTIVE, d_de=1: pix_cnt++ (saturates at 4095); accumulate d_pix.
- ACTIVE, d_de=0: go to HBLANK.
  - If pix_cnt!=H_ACTIVE, set the frame-local width error.
  - On line 1, latch pix_cnt as width.
- HBLANK, d_de=1: go to ACTIVE; line_cnt++ (saturates at 4095); pix_cnt=1; accumulate d_pix.
  - On the rise that starts line 2, latch htot_cnt as htotal.
- htot_cnt: increments every cycle from the line-1 rise until the line-2 rise; saturates.
- HBLANK, low_cnt==VBLANK_MIN: go to VBLANK. On the next clock edge:
  - frame_valid=1 for one cycle.
  - meas_width, meas_height=line_cnt, meas_htotal (0 for a single-line frame), frame_sum, err_width and err_height=(line_cnt!=V_ACTIVE) are loaded.
  - Result: frame_valid rises VBLANK_MIN+1 edges after the edge that first registered DE low.
- Outputs hold between frame_valid pulses.
- Checksum (default): frame_sum = sum of 16-bit d_pix over all active cycles, mod 2^16.
- locked:
  - A 2-bit good-frame counter increments on each error-free frame_valid and saturates at 2.
  - It clears on any frame with an error.
  - locked = (count==2), updated in the same cycle as frame_valid.
- Simultaneous events: DE rising in the same cycle that low_cnt reaches VBLANK_MIN resolves as end-of-frame first; that DE-high cycle starts the next frame from VBLANK.
- DE stuck high: no frame end. Counters saturate, and the frame is reported after DE falls and VBLANK_MIN low cycles elapse.

Optional Feature:
- Macro: LCDMON_CRC_EN.
- Defined: frame_sum is CRC-16-CCITT (polynomial 0x1021, init 0xFFFF, no reflection, no final XOR) over each 16-bit d_pix, MSB first, one pixel per cycle. The CRC is reseeded to 0xFFFF at frame start.
- Undefined: additive checksum as above; no CRC logic is synthesized.

Test Plan:
- Nominal frames, 3 frames of 480x272, hblank 80, vblank 29 lines, all pixels 0x0001.
  - Each frame: frame_valid; width 480, height 272, htotal 560, frame_sum 0xFE00, errors 0.
  - locked=0 after the first pulse and 1 after the second.
- Short line, frame 3 line 100 has 479 pixels -> err_width=1, meas_width=480, locked falls to 0 at that pulse; the next good frame leaves locked 0 and the following one sets 1.
- Height error, 271 lines -> meas_height=271, err_height=1, locked=0.
- Reset mid-frame, nRST low at line 50 then released -> all outputs 0 immediately; the block resumes in UNSYNC; no frame_valid until the first full frame after a vblank; that frame reports 480/272 with errors 0.
- Start after reset mid-frame -> first vblank produces no pulse; the next frame_valid reports a complete, correct frame.
- Stuck DE, high for 5000 cycles then normal vblank -> frame_valid with meas_width=4095, meas_height=1, meas_htotal=0, err_width=1, err_height=1.

Source files
------------

// File: rtl/lcd_de_monitor.sv
// Receive-side monitor for a DE-mode RGB565 panel bus: recovers per-frame geometry, checksum, errors and lock.
// Optional LCDMON_CRC_EN selects a CRC-16-CCITT frame_sum in place of the additive checksum.
module lcd_de_monitor #(
    parameter int unsigned H_ACTIVE   = 480,
    parameter int unsigned V_ACTIVE   = 272,
    parameter int unsigned VBLANK_MIN = 1024,
    parameter int unsigned CNT_W      = 16
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic        LCD_DE,
    input  logic [4:0]  LCD_R,
    input  logic [5:0]  LCD_G,
    input  logic [4:0]  LCD_B,
    output logic        frame_valid,
    output logic [11:0] meas_width,
    output logic [11:0] meas_height,
    output logic [15:0] meas_htotal,
    output logic [15:0] frame_sum,
    output logic        err_width,
    output logic        err_height,
    output logic        locked
);

    localparam int unsigned PIX_W = 16;
    localparam int unsigned GEO_W = 12;
    localparam int unsigned OUT_HT_W = 16;

    localparam logic [GEO_W-1:0] GEO_MAX = '1;
    localparam logic [GEO_W-1:0] GEO_ONE = GEO_W'(1);
    localparam logic [GEO_W-1:0] H_EXP   = GEO_W'(H_ACTIVE);
    localparam logic [GEO_W-1:0] V_EXP   = GEO_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] VB_MIN  = CNT_W'(VBLANK_MIN);

    localparam logic [1:0] GOOD_MAX = 2'd2;

    localparam logic [1:0] ST_UNSYNC = 2'd0;
    localparam logic [1:0] ST_VBLANK = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_HBLANK = 2'd3;

`ifdef LCDMON_CRC_EN
    localparam logic [PIX_W-1:0] SUM_INIT = 16'hFFFF;

    // One CRC-16-CCITT update over a full pixel word, MSB first.
    function automatic logic [PIX_W-1:0] sum_step(input logic [PIX_W-1:0] acc,
                                                  input logic [PIX_W-1:0] pix);
        logic [PIX_W-1:0] crc;
        crc = acc;
        for (int i = PIX_W - 1; i >= 0; i--) begin
            if (crc[PIX_W-1] ^ pix[i]) begin
                crc = {crc[PIX_W-2:0], 1'b0} ^ 16'h1021;
            end else begin
                crc = {crc[PIX_W-2:0], 1'b0};
            end
        end
        return crc;
    endfunction
`else
    localparam logic [PIX_W-1:0] SUM_INIT = 16'h0000;

    function automatic logic [PIX_W-1:0] sum_step(input logic [PIX_W-1:0] acc,
                                                  input logic [PIX_W-1:0] pix);
        return acc + pix;
    endfunction
`endif

    logic               d_de;
    logic [PIX_W-1:0]   d_pix;
    logic [CNT_W-1:0]   low_cnt;
    logic [1:0]         state;
    logic [1:0]         state_nxt;

    logic [GEO_W-1:0]   line_cnt;
    logic [GEO_W-1:0]   pix_cnt;
    logic [CNT_W-1:0]   htot_cnt;
    logic [CNT_W-1:0]   htotal_q;
    logic [GEO_W-1:0]   width_q;
    logic               werr_q;
    logic [PIX_W-1:0]   sum_q;
    logic [1:0]         good_cnt;

    logic               vb_hit_c;
    logic               htot_run_c;
    logic               start_c;
    logic               rise_c;
    logic               fall_c;
    logic               acc_c;
    logic               frame_end_c;
    logic               herr_c;
    logic [1:0]         good_nxt_c;

    // Input capture stage
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            d_de  <= 1'b0;
            d_pix <= '0;
        end else begin
            d_de  <= LCD_DE;
            d_pix <= {LCD_R, LCD_G, LCD_B};
        end
    end

    // Consecutive DE-low run length, saturating
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            low_cnt <= '0;
        end else if (d_de) begin
            low_cnt <= '0;
        end else if (low_cnt != CNT_MAX) begin
            low_cnt <= low_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state <= ST_UNSYNC;
        end else begin
            state <= state_nxt;
        end
    end

    assign vb_hit_c   = (low_cnt == VB_MIN);
    assign htot_run_c = ((state == ST_ACTIVE) || (state == ST_HBLANK)) && (line_cnt == GEO_ONE);

    // End of frame takes priority over a coincident DE rise, which then opens the next frame.
    always_comb begin
        state_nxt   = state;
        start_c     = 1'b0;
        rise_c      = 1'b0;
        fall_c      = 1'b0;
        acc_c       = 1'b0;
        frame_end_c = 1'b0;
        case (state)
            ST_UNSYNC: begin
                if (vb_hit_c) begin
                    if (d_de) begin
                        start_c   = 1'b1;
                        state_nxt = ST_ACTIVE;
                    end else begin
                        state_nxt = ST_VBLANK;
                    end
                end
            end
            ST_VBLANK: begin
                if (d_de) begin
                    start_c   = 1'b1;
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (d_de) begin
                    acc_c = 1'b1;
                end else begin
                    fall_c    = 1'b1;
                    state_nxt = ST_HBLANK;
                end
            end
            ST_HBLANK: begin
                if (vb_hit_c) begin
                    frame_end_c = 1'b1;
                    if (d_de) begin
                        start_c   = 1'b1;
                        state_nxt = ST_ACTIVE;
                    end else begin
                        state_nxt = ST_VBLANK;
                    end
                end else if (d_de) begin
                    rise_c    = 1'b1;
                    state_nxt = ST_ACTIVE;
                end
            end
            default: state_nxt = ST_UNSYNC;
        endcase
    end

    assign herr_c = (line_cnt != V_EXP);

    always_comb begin
        good_nxt_c = good_cnt;
        if (werr_q || herr_c) begin
            good_nxt_c = 2'd0;
        end else if (good_cnt != GOOD_MAX) begin
            good_nxt_c = good_cnt + 2'd1;
        end
    end

    // Per-frame measurement accumulators
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            line_cnt <= '0;
            pix_cnt  <= '0;
            htot_cnt <= '0;
            htotal_q <= '0;
            width_q  <= '0;
            werr_q   <= 1'b0;
            sum_q    <= '0;
        end else if (start_c) begin
            line_cnt <= GEO_ONE;
            pix_cnt  <= GEO_ONE;
            htot_cnt <= CNT_ONE;
            htotal_q <= '0;
            width_q  <= '0;
            werr_q   <= 1'b0;
            sum_q    <= sum_step(SUM_INIT, d_pix);
        end else begin
            if (htot_run_c && (htot_cnt != CNT_MAX)) begin
                htot_cnt <= htot_cnt + CNT_ONE;
            end
            if (acc_c) begin
                if (pix_cnt != GEO_MAX) begin
                    pix_cnt <= pix_cnt + GEO_ONE;
                end
                sum_q <= sum_step(sum_q, d_pix);
            end
            if (fall_c) begin
                if (pix_cnt != H_EXP) begin
                    werr_q <= 1'b1;
                end
                if (line_cnt == GEO_ONE) begin
                    width_q <= pix_cnt;
                end
            end
            if (rise_c) begin
                if (line_cnt != GEO_MAX) begin
                    line_cnt <= line_cnt + GEO_ONE;
                end
                if (line_cnt == GEO_ONE) begin
                    htotal_q <= htot_cnt;
                end
                pix_cnt <= GEO_ONE;
                sum_q   <= sum_step(sum_q, d_pix);
            end
        end
    end

    // Frame report registers, held between pulses
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            frame_valid <= 1'b0;
            meas_width  <= '0;
            meas_height <= '0;
            meas_htotal <= '0;
            frame_sum   <= '0;
            err_width   <= 1'b0;
            err_height  <= 1'b0;
            locked      <= 1'b0;
            good_cnt    <= '0;
        end else begin
            frame_valid <= frame_end_c;
            if (frame_end_c) begin
                meas_width  <= width_q;
                meas_height <= line_cnt;
                meas_htotal <= OUT_HT_W'(htotal_q);
                frame_sum   <= sum_q;
                err_width   <= werr_q;
                err_height  <= herr_c;
                good_cnt    <= good_nxt_c;
                locked      <= (good_nxt_c == GOOD_MAX);
            end
        end
    end

endmodule

// File: tb/tb_lcd_de_monitor.sv
// Directed bench for lcd_de_monitor using a scaled panel: 48x20 active, 8-cycle hblank, 3-line vblank.
module tb_lcd_de_monitor;

    localparam int unsigned HA = 48;
    localparam int unsigned VA = 20;
    localparam int unsigned VBM = 100;
    localparam int unsigned HBL = 8;
    localparam int unsigned VBL = 168;

    logic        clk;
    logic        rst_n;
    logic        lcd_de;
    logic [4:0]  lcd_r;
    logic [5:0]  lcd_g;
    logic [4:0]  lcd_b;
    logic        frame_valid;
    logic [11:0] meas_width;
    logic [11:0] meas_height;
    logic [15:0] meas_htotal;
    logic [15:0] frame_sum;
    logic        err_width;
    logic        err_height;
    logic        locked;

    int          n_pass;
    int          n_chk;
    int          pulse_cnt;
    int          lows;
    int          fv_lat;
    logic [11:0] cap_w;
    logic [11:0] cap_h;
    logic [15:0] cap_ht;
    logic [15:0] cap_sum;
    logic        cap_ew;
    logic        cap_eh;
    logic        cap_lock;
    logic [15:0] mdl;
    logic [15:0] exp_sum;

    lcd_de_monitor #(
        .H_ACTIVE   (HA),
        .V_ACTIVE   (VA),
        .VBLANK_MIN (VBM),
        .CNT_W      (16)
    ) dut (
        .PixelClk    (clk),
        .nRST        (rst_n),
        .LCD_DE      (lcd_de),
        .LCD_R       (lcd_r),
        .LCD_G       (lcd_g),
        .LCD_B       (lcd_b),
        .frame_valid (frame_valid),
        .meas_width  (meas_width),
        .meas_height (meas_height),
        .meas_htotal (meas_htotal),
        .frame_sum   (frame_sum),
        .err_width   (err_width),
        .err_height  (err_height),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LCDMON_CRC_EN
    localparam logic [15:0] MDL_INIT = 16'hFFFF;
    function automatic logic [15:0] mdl_step(input logic [15:0] a, input logic [15:0] p);
        logic [15:0] c;
        logic        fb;
        c = a;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ p[i];
            c = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction
`else
    localparam logic [15:0] MDL_INIT = 16'h0000;
    function automatic logic [15:0] mdl_step(input logic [15:0] a, input logic [15:0] p);
        return a + p;
    endfunction
`endif

    // One pixel clock of stimulus; snapshots the report whenever frame_valid is seen.
    task automatic drive_cyc(input logic de, input logic [15:0] pix);
        lcd_de = de;
        lcd_r  = pix[15:11];
        lcd_g  = pix[10:5];
        lcd_b  = pix[4:0];
        if (de) lows = 0;
        else lows++;
        @(posedge clk);
        #1;
        if (frame_valid === 1'b1) begin
            pulse_cnt++;
            fv_lat   = lows;
            cap_w    = meas_width;
            cap_h    = meas_height;
            cap_ht   = meas_htotal;
            cap_sum  = frame_sum;
            cap_ew   = err_width;
            cap_eh   = err_height;
            cap_lock = locked;
        end
    endtask

    task automatic drive_low(input int n);
        for (int i = 0; i < n; i++) drive_cyc(1'b0, 16'h0000);
    endtask

    task automatic drive_line(input int len, input logic [15:0] lbase, input bit flat);
        logic [15:0] pix;
        for (int p = 0; p < len; p++) begin
            pix = flat ? 16'h0001 : 16'(lbase + 16'(p * 37));
            mdl = mdl_step(mdl, pix);
            drive_cyc(1'b1, pix);
        end
    endtask

    // Lines first..last; the trailing low run after the last line is 'trail' cycles.
    task automatic drive_frame(input int first, input int last, input int short_line,
                               input int short_len, input int trail,
                               input logic [15:0] base, input bit flat);
        int len;
        if (first == 1) mdl = MDL_INIT;
        for (int l = first; l <= last; l++) begin
            len = (l == short_line) ? short_len : int'(HA);
            drive_line(len, 16'(base + 16'(l * 256)), flat);
            if (l < last) begin
                drive_low(HBL);
            end else begin
                exp_sum = mdl;
                drive_low(trail);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) drive_cyc(1'(i & 1), 16'(16'h5A5A + i));
        n_chk++; if (frame_valid !== 1'b0) $display("FAIL rst_fv got %b exp 0", frame_valid); else n_pass++;
        n_chk++; if (meas_width !== 12'd0) $display("FAIL rst_width got %0d exp 0", meas_width); else n_pass++;
        n_chk++; if (meas_height !== 12'd0) $display("FAIL rst_height got %0d exp 0", meas_height); else n_pass++;
        n_chk++; if (meas_htotal !== 16'd0) $display("FAIL rst_htotal got %0d exp 0", meas_htotal); else n_pass++;
        n_chk++; if (frame_sum !== 16'd0) $display("FAIL rst_sum got %h exp 0", frame_sum); else n_pass++;
        n_chk++; if ({err_width, err_height, locked} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {err_width, err_height, locked}); else n_pass++;
        rst_n = 1'b1;
        // First vblank after reset only synchronises, no report.
        drive_low(200);
        n_chk++; if (pulse_cnt !== 0) $display("FAIL sync_no_pulse got %0d exp 0", pulse_cnt); else n_pass++;
    endtask

    task automatic test_nominal();
        int pc;
        for (int f = 0; f < 3; f++) begin
            pc = pulse_cnt;
            drive_frame(1, VA, 0, 0, VBL, 16'(f * 4099), f == 0);
            n_chk++; if (pulse_cnt !== pc + 1) $display("FAIL nom%0d_pulses got %0d exp %0d", f, pulse_cnt, pc + 1); else n_pass++;
            n_chk++; if (cap_w !== 12'd48) $display("FAIL nom%0d_width got %0d exp 48", f, cap_w); else n_pass++;
            n_chk++; if (cap_h !== 12'd20) $display("FAIL nom%0d_height got %0d exp 20", f, cap_h); else n_pass++;
            n_chk++; if (cap_ht !== 16'd56) $display("FAIL nom%0d_htotal got %0d exp 56", f, cap_ht); else n_pass++;
            n_chk++; if (cap_sum !== exp_sum) $display("FAIL nom%0d_sum got %h exp %h", f, cap_sum, exp_sum); else n_pass++;
            n_chk++; if ({cap_ew, cap_eh} !== 2'b00) $display("FAIL nom%0d_errs got %b exp 00", f, {cap_ew, cap_eh}); else n_pass++;
            n_chk++; if (cap_lock !== (f >= 1)) $display("FAIL nom%0d_locked got %b exp %b", f, cap_lock, f >= 1); else n_pass++;
            n_chk++; if (fv_lat !== int'(VBM) + 2) $display("FAIL nom%0d_latency got %0d exp %0d", f, fv_lat, VBM + 2); else n_pass++;
`ifndef LCDMON_CRC_EN
            if (f == 0) begin
                n_chk++; if (cap_sum !== 16'h03C0) $display("FAIL nom_flat_sum got %h exp 03c0", cap_sum); else n_pass++;
            end
`endif
        end
        n_chk++; if (meas_height !== 12'd20) $display("FAIL hold_height got %0d exp 20", meas_height); else n_pass++;
    endtask

    task automatic test_short_line();
        drive_frame(1, VA, 10, 47, VBL, 16'h3C00, 1'b0);
        n_chk++; if (cap_ew !== 1'b1) $display("FAIL short_errw got %b exp 1", cap_ew); else n_pass++;
        n_chk++; if (cap_w !== 12'd48) $display("FAIL short_width got %0d exp 48", cap_w); else n_pass++;
        n_chk++; if (cap_eh !== 1'b0) $display("FAIL short_errh got %b exp 0", cap_eh); else n_pass++;
        n_chk++; if (cap_sum !== exp_sum) $display("FAIL short_sum got %h exp %h", cap_sum, exp_sum); else n_pass++;
        n_chk++; if (cap_lock !== 1'b0) $display("FAIL short_locked got %b exp 0", cap_lock); else n_pass++;
        drive_frame(1, VA, 0, 0, VBL, 16'h0777, 1'b0);
        n_chk++; if ({cap_ew, cap_lock} !== 2'b00) $display("FAIL relock1 got ew/lock %b exp 00", {cap_ew, cap_lock}); else n_pass++;
        drive_frame(1, VA, 0, 0, VBL, 16'h0888, 1'b0);
        n_chk++; if ({cap_ew, cap_lock} !== 2'b01) $display("FAIL relock2 got ew/lock %b exp 01", {cap_ew, cap_lock}); else n_pass++;
    endtask

    task automatic test_height();
        drive_frame(1, VA - 1, 0, 0, VBL, 16'h1111, 1'b0);
        n_chk++; if (cap_h !== 12'd19) $display("FAIL height_val got %0d exp 19", cap_h); else n_pass++;
        n_chk++; if ({cap_ew, cap_eh} !== 2'b01) $display("FAIL height_errs got %b exp 01", {cap_ew, cap_eh}); else n_pass++;
        n_chk++; if (cap_lock !== 1'b0) $display("FAIL height_locked got %b exp 0", cap_lock); else n_pass++;
        n_chk++; if (cap_ht !== 16'd56) $display("FAIL height_htotal got %0d exp 56", cap_ht); else n_pass++;
    endtask

    // Vblank of exactly VBLANK_MIN lows: next DE rise coincides with end-of-frame.
    task automatic test_back_to_back();
        int pc;
        logic [15:0] sa;
        drive_frame(1, VA, 0, 0, VBM, 16'h0A0A, 1'b0);
        sa = exp_sum;
        pc = pulse_cnt;
        drive_frame(1, 1, 0, 0, HBL, 16'h0B0B, 1'b0);
        n_chk++; if (pulse_cnt !== pc + 1) $display("FAIL b2b_a_pulse got %0d exp %0d", pulse_cnt, pc + 1); else n_pass++;
        n_chk++; if (cap_h !== 12'd20) $display("FAIL b2b_a_height got %0d exp 20", cap_h); else n_pass++;
        n_chk++; if (cap_sum !== sa) $display("FAIL b2b_a_sum got %h exp %h", cap_sum, sa); else n_pass++;
        n_chk++; if (cap_lock !== 1'b0) $display("FAIL b2b_a_locked got %b exp 0", cap_lock); else n_pass++;
        drive_frame(2, VA, 0, 0, VBL, 16'h0B0B, 1'b0);
        n_chk++; if (pulse_cnt !== pc + 2) $display("FAIL b2b_b_pulse got %0d exp %0d", pulse_cnt, pc + 2); else n_pass++;
        n_chk++; if ({cap_w, cap_h} !== {12'd48, 12'd20}) $display("FAIL b2b_b_geom got %0d/%0d exp 48/20", cap_w, cap_h); else n_pass++;
        n_chk++; if (cap_ht !== 16'd56) $display("FAIL b2b_b_htotal got %0d exp 56", cap_ht); else n_pass++;
        n_chk++; if (cap_sum !== exp_sum) $display("FAIL b2b_b_sum got %h exp %h", cap_sum, exp_sum); else n_pass++;
        n_chk++; if ({cap_ew, cap_eh, cap_lock} !== 3'b001) $display("FAIL b2b_b_flags got %b exp 001", {cap_ew, cap_eh, cap_lock}); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int pc;
        drive_frame(1, 4, 0, 0, HBL, 16'h2222, 1'b0);
        drive_line(24, 16'h2722, 1'b0);
        rst_n = 1'b0;
        #1;
        n_chk++; if ({meas_width, meas_height} !== 24'd0) $display("FAIL midrst_geom got %0d/%0d exp 0/0", meas_width, meas_height); else n_pass++;
        n_chk++; if ({meas_htotal, frame_sum} !== 32'd0) $display("FAIL midrst_ht_sum got %0d/%h exp 0/0", meas_htotal, frame_sum); else n_pass++;
        n_chk++; if ({frame_valid, err_width, err_height, locked} !== 4'b0000) $display("FAIL midrst_flags got %b exp 0000", {frame_valid, err_width, err_height, locked}); else n_pass++;
        drive_line(2, 16'h2740, 1'b0);
        rst_n = 1'b1;
        pc = pulse_cnt;
        drive_line(22, 16'h2750, 1'b0);
        drive_low(HBL);
        drive_frame(6, VA, 0, 0, VBL, 16'h2222, 1'b0);
        n_chk++; if (pulse_cnt !== pc) $display("FAIL midrst_no_pulse got %0d exp %0d", pulse_cnt, pc); else n_pass++;
        drive_frame(1, VA, 0, 0, VBL, 16'h3333, 1'b0);
        n_chk++; if (pulse_cnt !== pc + 1) $display("FAIL midrst_resume_pulse got %0d exp %0d", pulse_cnt, pc + 1); else n_pass++;
        n_chk++; if ({cap_w, cap_h} !== {12'd48, 12'd20}) $display("FAIL midrst_resume_geom got %0d/%0d exp 48/20", cap_w, cap_h); else n_pass++;
        n_chk++; if (cap_sum !== exp_sum) $display("FAIL midrst_resume_sum got %h exp %h", cap_sum, exp_sum); else n_pass++;
        n_chk++; if ({cap_ew, cap_eh, cap_lock} !== 3'b000) $display("FAIL midrst_resume_flags got %b exp 000", {cap_ew, cap_eh, cap_lock}); else n_pass++;
    endtask

    task automatic test_stuck_de();
        int pc;
        pc = pulse_cnt;
        drive_frame(1, 1, 1, 5000, 200, 16'h4444, 1'b0);
        n_chk++; if (pulse_cnt !== pc + 1) $display("FAIL stuck_pulse got %0d exp %0d", pulse_cnt, pc + 1); else n_pass++;
        n_chk++; if (cap_w !== 12'd4095) $display("FAIL stuck_width got %0d exp 4095", cap_w); else n_pass++;
        n_chk++; if (cap_h !== 12'd1) $display("FAIL stuck_height got %0d exp 1", cap_h); else n_pass++;
        n_chk++; if (cap_ht !== 16'd0) $display("FAIL stuck_htotal got %0d exp 0", cap_ht); else n_pass++;
        n_chk++; if ({cap_ew, cap_eh, cap_lock} !== 3'b110) $display("FAIL stuck_flags got %b exp 110", {cap_ew, cap_eh, cap_lock}); else n_pass++;
        n_chk++; if (cap_sum !== exp_sum) $display("FAIL stuck_sum got %h exp %h", cap_sum, exp_sum); else n_pass++;
        n_chk++; if (fv_lat !== int'(VBM) + 2) $display("FAIL stuck_latency got %0d exp %0d", fv_lat, VBM + 2); else n_pass++;
    endtask

    initial begin
        n_pass    = 0;
        n_chk     = 0;
        pulse_cnt = 0;
        lows      = 0;
        fv_lat    = 0;
        mdl       = MDL_INIT;
        exp_sum   = MDL_INIT;
        rst_n     = 1'b0;
        lcd_de    = 1'b0;
        lcd_r     = '0;
        lcd_g     = '0;
        lcd_b     = '0;
        test_reset();
        test_nominal();
        test_short_line();
        test_height();
        test_back_to_back();
        test_reset_mid();
        test_stuck_de();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
